pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: four-state fetch/execute sequencer. It produces the next value for
// an external 8-bit program-counter register, which loads PCin on every clock edge.
// Optional feature: define PC_CALL_STACK_EN to add a 4-entry return-address stack
// that serves call/ret. Without it, call and ret are ignored and stack_err stays 0.
//
// Handshake: the fetch request is level-based. imem_req stays high for every cycle in
// FETCH, and the fetch completes on the clock edge where imem_ack is sampled high.
// instr_done completes the instruction on the edge where it is sampled high in EXEC.
// The bench can observe FSM progress on the internal `state` register.
module pc_sequencer (
    input  logic       clock_reg,
    input  logic       reset,
    input  logic [7:0] PC,
    input  logic       start,
    input  logic       imem_ack,
    input  logic       instr_done,
    input  logic       jump,
    input  logic [7:0] jump_target,
    input  logic       branch,
    input  logic [7:0] branch_target,
    input  logic       halt,
    input  logic       call,
    input  logic       ret,
    output logic [7:0] PCin,
    output logic       imem_req,
    output logic       busy,
    output logic       halted,
    output logic       wrap,
    output logic       stack_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state;

    logic [7:0] pc_inc;
    logic       take;
    logic       sel_call;
    logic       sel_ret;
    logic       push_ok;
    logic       pop_ok;
    logic [7:0] stack_top;
    logic       use_inc;

    assign pc_inc = PC + 8'd1;
    // The next-PC fields only matter on the completing edge of an instruction.
    assign take   = (state == EXEC) && instr_done;

`ifdef PC_CALL_STACK_EN
    logic [7:0] stack_mem [0:3];
    logic [2:0] sp;
    logic       stack_full;
    logic       stack_empty;

    assign stack_full  = (sp == 3'd4);
    assign stack_empty = (sp == 3'd0);
    assign sel_call    = take && !halt && !jump && !branch && call;
    assign sel_ret     = take && !halt && !jump && !branch && !call && ret;
    assign push_ok     = sel_call && !stack_full;
    assign pop_ok      = sel_ret && !stack_empty;
    assign stack_top   = stack_mem[sp[1:0] - 2'd1];

    // Return-address stack: push PC+1 on call and pop on ret. A push when the stack
    // is full, or a pop when it is empty, leaves the stack unchanged and latches
    // stack_err.
    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            sp        <= 3'd0;
            stack_err <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stack_mem[i] <= 8'h00;
            end
        end else begin
            if (push_ok) begin
                stack_mem[sp[1:0]] <= pc_inc;
                sp                 <= sp + 3'd1;
            end else if (pop_ok) begin
                sp <= sp - 3'd1;
            end
            if ((sel_call && stack_full) || (sel_ret && stack_empty)) begin
                stack_err <= 1'b1;
            end
        end
    end
`else
    logic unused_stack_inputs;

    assign unused_stack_inputs = &{1'b0, call, ret};
    assign sel_call  = 1'b0;
    assign sel_ret   = 1'b0;
    assign push_ok   = 1'b0;
    assign pop_ok    = 1'b0;
    assign stack_top = 8'h00;
    assign stack_err = 1'b0;
`endif

    // Next-PC select. The register holds its value unless an instruction is completing.
    // Priority is halt > jump > branch > call > ret > increment.
    always_comb begin
        PCin    = PC;
        use_inc = 1'b0;
        if (take) begin
            if (halt) begin
                PCin = PC;
            end else if (jump) begin
                PCin = jump_target;
            end else if (branch) begin
                PCin = branch_target;
            end else if (sel_call) begin
                if (push_ok) begin
                    PCin = jump_target;
                end else begin
                    use_inc = 1'b1;
                end
            end else if (sel_ret) begin
                if (pop_ok) begin
                    PCin = stack_top;
                end else begin
                    use_inc = 1'b1;
                end
            end else begin
                use_inc = 1'b1;
            end
            if (use_inc) begin
                PCin = pc_inc;
            end
        end
    end

    // Sequencer FSM. imem_req, busy and halted are registered together with the state,
    // so each one is always a pure function of the current state.
    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            wrap <= take && use_inc && (PC == 8'hFF);
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        state    <= EXEC;
                        imem_req <= 1'b0;
                    end
                end
                EXEC: begin
                    if (instr_done) begin
                        if (halt) begin
                            state    <= HALTED;
                            imem_req <= 1'b0;
                            busy     <= 1'b0;
                            halted   <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= HALTED;
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                    halted   <= 1'b1;
                end
            endcase
        end
    end

endmodule
